video_frame_source: RTL and testbench

Frame-playback source that drives a video stream in the team's v_sync/h_sync/data format from a synchronous-read frame memory. It is the producer for downstream stream consumers such as the dual-image subtraction stage and other pixel filters. It generates frame and line timing with programmable blanking, reads pixels in raster order, and aligns the read data with the sync outputs. Instantiating it twice with a common i_start yields the two aligned streams the dual-input stages require.

---
 rtl/video_frame_source_pkg.sv | 29 ++
 rtl/video_sync_delay.sv | 28 ++
 rtl/video_frame_source.sv | 139 +++++++++++++
 tb/tb_video_frame_source.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/video_frame_source_pkg.sv
// Shared state encoding and sizing helpers for the frame-playback source.
package video_frame_source_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME_PRE,
        ST_LINE_ACT,
        ST_LINE_BLANK,
        ST_FRAME_POST,
        ST_FRAME_GAP
    } vfs_state_e;

    // Sync/data latency from the FSM to the stream outputs
    localparam int VFS_SYNC_STAGES = 2;

    function automatic int vfs_cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int vfs_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int vfs_frame_period(input int w, input int h, input int hb,
                                            input int v_pre, input int v_post, input int v_gap);
        return v_pre + h * (w + hb) + v_post + v_gap;
    endfunction

endpackage

// File: rtl/video_sync_delay.sv
// N-stage register for stream sync bits; exposes the first stage and the final stage.
module video_sync_delay #(
    parameter int P_WIDTH  = 2,
    parameter int P_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [P_WIDTH-1:0] i_sig,
    output logic [P_WIDTH-1:0] o_first,
    output logic [P_WIDTH-1:0] o_sig
);

    logic [P_STAGES:1][P_WIDTH-1:0] pipe_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[1] <= i_sig;
            for (int s = 2; s <= P_STAGES; s++)
                pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign o_first = pipe_q[1];
    assign o_sig   = pipe_q[P_STAGES];

endmodule

// File: rtl/video_frame_source.sv
// Frame-playback stream source: raster reads from a sync-read frame memory with
// programmable blanking, read data aligned to the delayed v/h syncs.
module video_frame_source
    import video_frame_source_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_IMG_WIDTH  = 256,
    parameter int P_IMG_HEIGHT = 256,
    parameter int P_ADDR_WIDTH = 16,
    parameter int P_H_BLANK    = 2,
    parameter int P_V_PRE      = 3,
    parameter int P_V_POST     = 1,
    parameter int P_V_GAP      = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_cont,
    input  logic [P_ADDR_WIDTH-1:0] i_base_addr,
    output logic                    o_rd_en,
    output logic [P_ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] i_rd_data,
    output logic                    o_v_sync,
    output logic                    o_h_sync,
    output logic [P_DATA_WIDTH-1:0] o_data,
    output logic                    o_busy,
    output logic                    o_frame_done
);

    localparam int COL_W = vfs_cnt_w(P_IMG_WIDTH);
    localparam int ROW_W = vfs_cnt_w(P_IMG_HEIGHT);
    localparam int PH_W  = vfs_cnt_w(vfs_max(vfs_max(P_V_PRE, P_H_BLANK),
                                             vfs_max(P_V_POST, P_V_GAP)));

    vfs_state_e              state_q, state_d;
    logic [PH_W-1:0]         ph_q;
    logic [COL_W-1:0]        col_q;
    logic [ROW_W-1:0]        row_q;
    logic [P_ADDR_WIDTH-1:0] run_addr_q, last_addr_q;
    logic                    ph_last, col_last, row_last, frame_start;
    logic                    v_int, h_int;
    logic [1:0]              vh_d1, vh_d2;

    assign col_last = (int'(col_q) == P_IMG_WIDTH - 1);
    assign row_last = (int'(row_q) == P_IMG_HEIGHT - 1);

    always_comb begin
        ph_last = 1'b0;
        case (state_q)
            ST_FRAME_PRE:  ph_last = (int'(ph_q) == P_V_PRE - 1);
            ST_LINE_BLANK: ph_last = (int'(ph_q) == P_H_BLANK - 1);
            ST_FRAME_POST: ph_last = (int'(ph_q) == P_V_POST - 1);
            ST_FRAME_GAP:  ph_last = (int'(ph_q) == P_V_GAP - 1);
            default:       ph_last = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        case (state_q)
            ST_IDLE: if (i_start) begin
                frame_start = 1'b1;
                state_d     = (P_V_PRE == 0) ? ST_LINE_ACT : ST_FRAME_PRE;
            end
            ST_FRAME_PRE:  if (ph_last) state_d = ST_LINE_ACT;
            ST_LINE_ACT:   if (col_last) state_d = ST_LINE_BLANK;
            ST_LINE_BLANK: if (ph_last) begin
                if (!row_last)          state_d = ST_LINE_ACT;
                else if (P_V_POST == 0) state_d = ST_FRAME_GAP;
                else                    state_d = ST_FRAME_POST;
            end
            ST_FRAME_POST: if (ph_last) state_d = ST_FRAME_GAP;
            ST_FRAME_GAP:  if (ph_last) begin
                if (i_cont) begin
                    frame_start = 1'b1;
                    state_d     = (P_V_PRE == 0) ? ST_LINE_ACT : ST_FRAME_PRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_rd_en   = (state_q == ST_LINE_ACT);
    assign o_busy    = (state_q != ST_IDLE);
    assign v_int     = (state_q inside {ST_FRAME_PRE, ST_LINE_ACT, ST_LINE_BLANK, ST_FRAME_POST});
    assign h_int     = o_rd_en;
    // Address holds between lines rather than showing the pre-incremented next line start
    assign o_rd_addr = o_rd_en ? run_addr_q : last_addr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ph_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            run_addr_q   <= '0;
            last_addr_q  <= '0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            ph_q  <= (state_d != state_q) ? '0 : ph_q + 1'b1;
            col_q <= (o_rd_en && !col_last) ? col_q + 1'b1 : '0;
            if (frame_start)
                row_q <= '0;
            else if (state_q == ST_LINE_BLANK && ph_last && !row_last)
                row_q <= row_q + 1'b1;
            if (frame_start)
                run_addr_q <= i_base_addr;
            else if (o_rd_en)
                run_addr_q <= run_addr_q + 1'b1;
            if (o_rd_en)
                last_addr_q <= run_addr_q;
            o_data       <= vh_d1[0] ? i_rd_data : '0;
            o_frame_done <= vh_d2[1] & ~vh_d1[1];
        end
    end

    video_sync_delay #(
        .P_WIDTH  (2),
        .P_STAGES (VFS_SYNC_STAGES)
    ) u_sync_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sig   ({v_int, h_int}),
        .o_first (vh_d1),
        .o_sig   (vh_d2)
    );

    assign o_v_sync = vh_d2[1];
    assign o_h_sync = vh_d2[0];

endmodule

// File: tb/tb_video_frame_source.sv
// Random-stimulus bench: two configurations (with and without vertical pre/post) checked
// cycle by cycle against a frame-position model derived from the timing rules.
module tb_video_frame_source;
    import video_frame_source_pkg::*;

    localparam int W = 4, H = 2, HB = 2;
    int cfg_pre[2]  = '{3, 0};
    int cfg_post[2] = '{1, 0};
    int cfg_gap[2]  = '{2, 2};
    int per[2];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, b_rst_n, a_start, b_start, a_cont, b_cont;
    logic [15:0] a_base, b_base, a_rd_addr, b_rd_addr;
    logic        a_rd_en, b_rd_en, a_vs, b_vs, a_hs, b_hs, a_busy, b_busy, a_fd, b_fd;
    logic [7:0]  a_rd_data, b_rd_data, a_data, b_data;

    logic        cur;
    logic        s_rd_en, s_vs, s_hs, s_busy, s_fd;
    logic [15:0] s_rd_addr;
    logic [7:0]  s_data;

    int          total = 0, bad = 0;
    int          bases[4];
    logic [15:0] hold[2];

    video_frame_source #(
        .P_DATA_WIDTH(8), .P_IMG_WIDTH(W), .P_IMG_HEIGHT(H), .P_ADDR_WIDTH(16),
        .P_H_BLANK(HB), .P_V_PRE(3), .P_V_POST(1), .P_V_GAP(2)
    ) dut_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_start(a_start), .i_cont(a_cont),
        .i_base_addr(a_base), .o_rd_en(a_rd_en), .o_rd_addr(a_rd_addr),
        .i_rd_data(a_rd_data), .o_v_sync(a_vs), .o_h_sync(a_hs), .o_data(a_data),
        .o_busy(a_busy), .o_frame_done(a_fd)
    );

    video_frame_source #(
        .P_DATA_WIDTH(8), .P_IMG_WIDTH(W), .P_IMG_HEIGHT(H), .P_ADDR_WIDTH(16),
        .P_H_BLANK(HB), .P_V_PRE(0), .P_V_POST(0), .P_V_GAP(2)
    ) dut_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_start(b_start), .i_cont(b_cont),
        .i_base_addr(b_base), .o_rd_en(b_rd_en), .o_rd_addr(b_rd_addr),
        .i_rd_data(b_rd_data), .o_v_sync(b_vs), .o_h_sync(b_hs), .o_data(b_data),
        .o_busy(b_busy), .o_frame_done(b_fd)
    );

    // Frame memory: mem[a] = a[7:0], one-cycle read latency, junk when not read
    always @(posedge clk) begin
        a_rd_data <= a_rd_en ? a_rd_addr[7:0] : 8'($urandom);
        b_rd_data <= b_rd_en ? b_rd_addr[7:0] : 8'($urandom);
    end

    assign s_rd_en   = cur ? b_rd_en   : a_rd_en;
    assign s_rd_addr = cur ? b_rd_addr : a_rd_addr;
    assign s_vs      = cur ? b_vs      : a_vs;
    assign s_hs      = cur ? b_hs      : a_hs;
    assign s_data    = cur ? b_data    : a_data;
    assign s_busy    = cur ? b_busy    : a_busy;
    assign s_fd      = cur ? b_fd      : a_fd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d t=%0t obs=%0h exp=%0h", tag, cur, $time, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"},  32'(s_busy),    32'd0);
        chk({tag, ".rd_en"}, 32'(s_rd_en),   32'd0);
        chk({tag, ".addr"},  32'(s_rd_addr), 32'd0);
        chk({tag, ".vs"},    32'(s_vs),      32'd0);
        chk({tag, ".hs"},    32'(s_hs),      32'd0);
        chk({tag, ".data"},  32'(s_data),    32'd0);
        chk({tag, ".fd"},    32'(s_fd),      32'd0);
    endtask

    task automatic drive(input logic st, input logic ct, input logic [15:0] bs);
        if (cur) begin b_start = st; b_cont = ct; b_base = bs; end
        else     begin a_start = st; a_cont = ct; a_base = bs; end
    endtask

    // Internal v/h for FSM-cycle index p counted from the first frame's first cycle
    function automatic void pos(input int sel, input int nfr, input int p,
                                output bit busy, output bit v, output bit h,
                                output int off, output int k);
        int f, q, ql;
        f = per[sel];
        busy = 0; v = 0; h = 0; off = 0; k = 0;
        if (p >= 0 && p < nfr * f) begin
            k    = p / f;
            q    = p % f;
            busy = 1;
            v    = (q < f - cfg_gap[sel]);
            ql   = q - cfg_pre[sel];
            if (ql >= 0 && ql < H * (W + HB)) begin
                h   = (ql % (W + HB)) < W;
                off = (ql / (W + HB)) * W + ql % (W + HB);
            end
        end
    endfunction

    // Cycle c: outputs checked mid-cycle, then inputs for cycle c driven; i_start at c=0.
    task automatic run(input int sel, input int nfr, input bit fix_stray,
                       input bit rnd_stray, input int abort);
        int f, p, d, k, kd, off, offd, k2;
        bit busy, v, h, bd, vd, hd, fd, dead, st, ct, samp;
        logic [15:0] eaddr, bs;
        logic [7:0]  edata;
        cur  = sel[0];
        f    = per[sel];
        dead = 0;
        for (int c = 0; c <= nfr * f + 4; c++) begin
            @(negedge clk);
            if (dead) begin a_rst_n = 1'b1; b_rst_n = 1'b1; end
            p = dead ? -100 : c - 1;
            d = p - 2;
            pos(sel, nfr, p, busy, v, h, off, k);
            pos(sel, nfr, d, bd, vd, hd, offd, kd);
            if (h) begin
                eaddr     = 16'(bases[k] + off);
                hold[sel] = eaddr;
            end else begin
                eaddr = hold[sel];
            end
            edata = hd ? 8'(bases[kd] + offd) : 8'h00;
            fd    = (d >= 0) && (d < nfr * f) && (d % f == f - cfg_gap[sel]);
            chk("busy",       32'(s_busy),    32'(busy));
            chk("rd_en",      32'(s_rd_en),   32'(h));
            chk("rd_addr",    32'(s_rd_addr), 32'(eaddr));
            chk("v_sync",     32'(s_vs),      32'(vd));
            chk("h_sync",     32'(s_hs),      32'(hd));
            chk("data",       32'(s_data),    32'(edata));
            chk("frame_done", 32'(s_fd),      32'(fd));

            k2   = (c - 1) / f;
            samp = !dead && c >= 1 && ((c - 1) % f == f - 1) && k2 < nfr;
            st   = !dead && (c == 0 || (fix_stray && (c == 5 || c == 10)) ||
                             (rnd_stray && c >= 1 && c <= nfr * f && $urandom_range(7) == 0));
            ct   = samp ? (k2 < nfr - 1) : 1'($urandom);
            if (!dead && c == 0)                 bs = 16'(bases[0]);
            else if (samp && k2 < nfr - 1)       bs = 16'(bases[k2 + 1]);
            else                                 bs = 16'($urandom);
            drive(st, ct, bs);

            if (c == abort) begin
                if (cur) b_rst_n = 1'b0; else a_rst_n = 1'b0;
                #1;
                chk_zero("abort");
                dead      = 1;
                hold[sel] = '0;
                drive(1'b0, 1'b0, 16'h0);
            end
        end
    endtask

    initial begin
        cur = 1'b0;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_start = 1'b0; b_start = 1'b0; a_cont = 1'b0; b_cont = 1'b0;
        a_base = '0; b_base = '0;
        hold[0] = '0; hold[1] = '0;
        for (int s = 0; s < 2; s++)
            per[s] = vfs_frame_period(W, H, HB, cfg_pre[s], cfg_post[s], cfg_gap[s]);
        repeat (3) @(negedge clk);
        cur = 1'b0; #1; chk_zero("reset");
        cur = 1'b1; #1; chk_zero("reset");
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        bases[0] = 16'h0010; bases[1] = 16'h0010;
        run(0, 1, 1, 0, -1);          // single frame, starts at cycles 5 and 10 ignored
        run(0, 2, 0, 0, -1);          // continuous, back-to-back frames
        run(0, 1, 0, 0, 8);           // reset mid-frame
        run(0, 1, 0, 0, -1);          // full frame after the abort
        bases[0] = 16'hFFFE;
        run(0, 1, 0, 0, -1);          // address wrap
        bases[0] = 16'h0010;
        run(1, 1, 0, 0, -1);          // no vertical pre/post
        bases[0] = 16'hFFFD; bases[1] = 16'h1234; bases[2] = 16'h0000;
        run(1, 3, 0, 0, -1);          // base re-latched per continuous frame

        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 4; j++) bases[j] = int'($urandom_range(16'hFFFF));
            run(int'($urandom_range(1)), int'($urandom_range(3, 1)), 1'b0, 1'b1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
